gpio_debounce_irq: RTL and testbench

GPIO_DEBOUNCE_IRQ -- requirements
Module: gpio_debounce_irq

---
 rtl/gpio_debounce_irq.sv | 109 ++++++++++
 tb/tb_gpio_debounce_irq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_irq.sv
// Per-channel GPIO input conditioning: synchroniser, saturating debounce counter,
// edge pulse generation and sticky interrupt pending flags with a masked IRQ line.
module gpio_debounce_irq #(
    parameter int NUM_CH          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int IRQ_MODE        = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] stable_o,
    output logic [NUM_CH-1:0] edge_o,
    input  logic [NUM_CH-1:0] irq_mask_i,
    input  logic [NUM_CH-1:0] irq_clr_i,
    output logic [NUM_CH-1:0] irq_pend_o,
    output logic              irq_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] stable_q;
    logic [NUM_CH-1:0] edge_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] edge_sel;
    logic [NUM_CH-1:0] set_cond;

    // NOTE: every synchroniser stage is a real flop, so each one is reset; a
    // non-reset stage would release stale levels into the debouncer after reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make the stages shift by one per edge;
            // blocking ones here would collapse the chain into a single flop.
            sync_q[0] <= raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             acc;

        // NOTE: defaults first so every path assigns every output -- no latches.
        always_comb begin
            cnt_d = '0;
            acc   = 1'b0;
            if (sync[n] != stable_q[n]) begin
                if (cnt_q == CNT_LAST) begin
                    acc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign accept[n] = acc;
    end

    // The selected polarity is judged on the already-updated stable level.
    always_comb begin
        edge_sel = '1;
        case (IRQ_MODE)
            0:       edge_sel = stable_q;
            1:       edge_sel = ~stable_q;
            default: edge_sel = '1;
        endcase
        set_cond = edge_q & edge_sel;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
        end else begin
            stable_q <= stable_q ^ accept;
            edge_q   <= accept;
            // Set wins over a simultaneous clear so no event is lost.
            pend_q   <= (pend_q & ~irq_clr_i) | set_cond;
        end
    end

    assign stable_o   = stable_q;
    assign edge_o     = edge_q;
    assign irq_pend_o = pend_q;
    assign irq_o      = |(pend_q & irq_mask_i);

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Self-checking bench for gpio_debounce_irq: hand sequences for the corner cases
// plus a vector table whose expectations flow through a scoreboard queue.
module tb_gpio_debounce_irq;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [3:0] raw, mask, clr;
    logic [3:0] stable, edge_p, pend;
    logic       irq;
    logic [3:0] raw_b, mask_b, clr_b;
    logic [3:0] stable_b, edge_b, pend_b;
    logic       irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_debounce_irq #(
        .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IRQ_MODE(2)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .raw_i(raw), .stable_o(stable),
        .edge_o(edge_p), .irq_mask_i(mask), .irq_clr_i(clr),
        .irq_pend_o(pend), .irq_o(irq)
    );

    gpio_debounce_irq #(
        .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .IRQ_MODE(0)
    ) dut_rise (
        .clk_i(clk), .arst_n_i(arst_n), .raw_i(raw_b), .stable_o(stable_b),
        .edge_o(edge_b), .irq_mask_i(mask_b), .irq_clr_i(clr_b),
        .irq_pend_o(pend_b), .irq_o(irq_b)
    );

    typedef struct {
        logic [3:0] raw;
        logic [3:0] mask;
        logic [3:0] clr;
        int         cycles;
        logic [3:0] exp_stable;
        logic [3:0] exp_pend;
        logic       exp_irq;
        logic [3:0] exp_edge;
    } vec_t;

    typedef struct {
        logic [3:0] stable;
        logic [3:0] pend;
        logic       irq;
        logic [3:0] edge_seen;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        raw    = '0;
        mask   = '0;
        clr    = '0;
        raw_b  = '0;
        mask_b = 4'b1000;
        clr_b  = '0;
        #1;
        tick();
        arst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 4'b1111, 4'b0000, 8, 4'b0001, 4'b0001, 1'b1, 4'b0001};
        vecs[1]  = '{4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0001, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0011, 4'b0010, 4'b0001, 8, 4'b0011, 4'b0010, 1'b1, 4'b0010};
        vecs[3]  = '{4'b0010, 4'b0000, 4'b0010, 5, 4'b0011, 4'b0000, 1'b0, 4'b0000};
        vecs[4]  = '{4'b0010, 4'b0001, 4'b0000, 3, 4'b0010, 4'b0001, 1'b1, 4'b0001};
        vecs[5]  = '{4'b0110, 4'b0100, 4'b0001, 7, 4'b0110, 4'b0100, 1'b1, 4'b0100};
        vecs[6]  = '{4'b1110, 4'b1111, 4'b0100, 2, 4'b0110, 4'b0000, 1'b0, 4'b0000};
        vecs[7]  = '{4'b0110, 4'b1111, 4'b0000, 8, 4'b0110, 4'b0000, 1'b0, 4'b0000};
        vecs[8]  = '{4'b1110, 4'b1000, 4'b0000, 4, 4'b0110, 4'b0000, 1'b0, 4'b0000};
        vecs[9]  = '{4'b0110, 4'b1000, 4'b0000, 3, 4'b1110, 4'b1000, 1'b1, 4'b1000};
        vecs[10] = '{4'b0110, 4'b0000, 4'b0000, 6, 4'b0110, 4'b1000, 1'b0, 4'b1000};
        vecs[11] = '{4'b0110, 4'b1111, 4'b1111, 2, 4'b0110, 4'b0000, 1'b0, 4'b0000};

        // Reset state.
        arst_n = 1'b0;
        raw = '0; mask = 4'b1111; clr = '0;
        raw_b = '0; mask_b = 4'b1000; clr_b = '0;
        #1;
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_edge",   32'(edge_p), 32'h0);
        check("rst_pend",   32'(pend),   32'h0);
        check("rst_irq",    32'(irq),    32'h0);
        do_reset();

        // ch0 rise: accepted on the 6th edge, pending one edge later.
        raw = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("rise_early_stable", 32'(stable), 32'h0);
        end
        tick();
        check("rise_stable", 32'(stable), 32'h1);
        check("rise_edge",   32'(edge_p), 32'h1);
        check("rise_pend0",  32'(pend),   32'h0);
        tick();
        check("rise_edge_off", 32'(edge_p), 32'h0);
        check("rise_pend",     32'(pend),   32'h1);
        check("masked_irq",    32'(irq),    32'h0);
        mask = 4'b0001;
        #1;
        check("unmask_irq", 32'(irq), 32'h1);
        clr = 4'b0001;
        tick();
        clr = '0;
        check("clr_pend", 32'(pend), 32'h0);
        check("clr_irq",  32'(irq),  32'h0);

        // ch1 three-cycle glitch is rejected.
        raw = 4'b0011;
        repeat (3) tick();
        raw = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_stable", 32'(stable), 32'h1);
            check("glitch_edge",   32'(edge_p), 32'h0);
            check("glitch_pend",   32'(pend),   32'h0);
        end

        // ch2 clear coincides with its set condition: set wins.
        raw = 4'b0101;
        repeat (5) tick();
        check("ch2_early", 32'(stable), 32'h1);
        tick();
        check("ch2_stable", 32'(stable), 32'h5);
        check("ch2_edge",   32'(edge_p), 32'h4);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("set_over_clr", 32'(pend), 32'h4);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("ch2_cleared", 32'(pend), 32'h0);

        // Rising-only instance: fall pulses edge but never sets pending.
        raw_b = 4'b1000;
        repeat (6) tick();
        check("m0_rise_edge",   32'(edge_b),   32'h8);
        check("m0_rise_stable", 32'(stable_b), 32'h8);
        tick();
        check("m0_rise_pend", 32'(pend_b), 32'h8);
        check("m0_rise_irq",  32'(irq_b),  32'h1);
        clr_b = 4'b1000;
        tick();
        clr_b = '0;
        check("m0_clr", 32'(pend_b), 32'h0);
        raw_b = 4'b0000;
        repeat (6) tick();
        check("m0_fall_edge",   32'(edge_b),   32'h8);
        check("m0_fall_stable", 32'(stable_b), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("m0_fall_pend", 32'(pend_b), 32'h0);
        end
        check("m0_fall_edge_off", 32'(edge_b), 32'h0);

        // Reset mid-debounce discards counts and synchroniser contents.
        do_reset();
        raw  = 4'hF;
        mask = 4'hF;
        repeat (4) tick();
        arst_n = 1'b0;
        #1;
        check("mid_rst_stable", 32'(stable), 32'h0);
        check("mid_rst_edge",   32'(edge_p), 32'h0);
        check("mid_rst_pend",   32'(pend),   32'h0);
        check("mid_rst_irq",    32'(irq),    32'h0);
        #2;
        arst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_early", 32'(stable), 32'h0);
        tick();
        check("post_rst_stable", 32'(stable), 32'hF);
        check("post_rst_edge",   32'(edge_p), 32'hF);
        tick();
        check("post_rst_pend", 32'(pend), 32'hF);
        check("post_rst_irq",  32'(irq),  32'h1);

        // Table-driven vectors through the scoreboard.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            exp_t e;
            logic [3:0] edge_seen;
            raw  = vecs[v].raw;
            mask = vecs[v].mask;
            clr  = vecs[v].clr;
            e.stable    = vecs[v].exp_stable;
            e.pend      = vecs[v].exp_pend;
            e.irq       = vecs[v].exp_irq;
            e.edge_seen = vecs[v].exp_edge;
            sb_q.push_back(e);
            edge_seen = '0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                clr = '0;
                edge_seen |= edge_p;
            end
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'(0), 32'(1));
            end else begin
                e = sb_q.pop_front();
                check($sformatf("vec%0d_stable", v), 32'(stable),    32'(e.stable));
                check($sformatf("vec%0d_pend", v),   32'(pend),      32'(e.pend));
                check($sformatf("vec%0d_irq", v),    32'(irq),       32'(e.irq));
                check($sformatf("vec%0d_edge", v),   32'(edge_seen), 32'(e.edge_seen));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
